// File: rtl/snf_rxreq_pkg.sv
// Shared CHI definitions for the SN-F request receiver: the request flit
// layout, REQ opcode constants and the architectural L-credit ceiling.
package snf_rxreq_pkg;

    // Largest number of L-credits a CHI link may have outstanding
    localparam int CHI_MAX_CRD = 15;

    // REQ channel opcodes used by the SN-F
    localparam logic [5:0] ReqLCrdReturn  = 6'h00;
    localparam logic [5:0] ReadNoSnp      = 6'h04;
    localparam logic [5:0] WriteNoSnpPtl  = 6'h1C;
    localparam logic [5:0] WriteNoSnpFull = 6'h1D;

    // Request flit (trimmed to the fields the SN-F pipeline consumes)
    typedef struct packed {
        logic [3:0]  qos;
        logic [10:0] tgt_id;
        logic [10:0] src_id;
        logic [11:0] txn_id;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [47:0] addr;
    } reqflit_t;

    // A credit-return flit carries no request and must not be buffered
    function automatic logic is_lcrd_return(input reqflit_t f);
        return f.opcode == ReqLCrdReturn;
    endfunction

endpackage

// File: rtl/chi_flit_fifo.sv
// Generic first-word-fall-through flit FIFO shared by the CHI receivers.
// Depth need not be a power of two; pointers wrap modulo DEPTH.
// A push into a full FIFO is ignored unless a pop frees the slot that cycle.
module chi_flit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Qualify handshakes and compute next pointer/count values
    always_comb begin
        pop_ok      = pop & (count_reg != '0);
        push_ok     = push & ((count_reg != CNT_W'(DEPTH)) | pop_ok);
        wr_ptr_next = push_ok ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop_ok  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and occupancy state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One register per entry so every slot clears on reset
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the incoming flit when this slot is the write target
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/snf_rxreq.sv
// SN-F CHI REQ link-layer receiver: grants L-credits, buffers request flits
// in a credit-sized FIFO and presents them to the memory pipeline.
module snf_rxreq
    import snf_rxreq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  reqflit_t         RXREQFLIT,
    input  logic             RXREQFLITV,
    input  logic             RXREQFLITPEND,
    output logic             RXREQLCRDV,
    output logic             req_valid,
    input  logic             req_ready,
    output reqflit_t         req_flit,
    output logic [CNT_W-1:0] occupancy,
    output logic             proto_err
);

    generate
        if (DEPTH < 1 || DEPTH > CHI_MAX_CRD) begin : g_bad_depth
            $error("snf_rxreq: DEPTH must lie in 1..CHI_MAX_CRD");
        end
    endgenerate

    logic [CNT_W-1:0] lcrd_cnt_reg, lcrd_cnt_next;
    logic             lcrdv_reg, lcrdv_next;
    logic             proto_err_reg, proto_err_next;
    logic [CNT_W-1:0] occupancy_next;

    logic             credit_avail;
    logic             is_return;
    logic             no_credit;
    logic             overflow;
    logic             do_push;
    logic             do_return;
    logic             do_pop;
    logic             consume;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [$bits(reqflit_t)-1:0] fifo_dout;

    // The early-flit hint carries no acceptance meaning here
    logic             unused_flitpend;
    assign unused_flitpend = RXREQFLITPEND;

    // Classify the incoming flit; a credit granted this cycle is usable now
    always_comb begin
        credit_avail = (lcrd_cnt_reg != '0) | lcrdv_reg;
        is_return    = is_lcrd_return(RXREQFLIT);
        do_pop       = !fifo_empty & req_ready;
        no_credit    = RXREQFLITV & !credit_avail;
        overflow     = RXREQFLITV & credit_avail & !is_return & fifo_full & !do_pop;
        do_return    = RXREQFLITV & credit_avail & is_return;
        do_push      = RXREQFLITV & credit_avail & !is_return & !(fifo_full & !do_pop);
        consume      = do_push | do_return;
    end

    // Credit bookkeeping: grant only while credits plus buffered flits fit
    always_comb begin
        lcrd_cnt_next  = lcrd_cnt_reg + CNT_W'(lcrdv_reg) - CNT_W'(consume);
        occupancy_next = fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);
        lcrdv_next     = ({1'b0, lcrd_cnt_next} + {1'b0, occupancy_next})
                         < (CNT_W + 1)'(DEPTH);
        proto_err_next = proto_err_reg | no_credit | overflow;
    end

    // Credit counter, grant pulse and sticky error state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lcrd_cnt_reg  <= '0;
            lcrdv_reg     <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            lcrd_cnt_reg  <= lcrd_cnt_next;
            lcrdv_reg     <= lcrdv_next;
            proto_err_reg <= proto_err_next;
        end
    end

    chi_flit_fifo #(
        .WIDTH ($bits(reqflit_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (do_push),
        .din   (RXREQFLIT),
        .pop   (do_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign RXREQLCRDV = lcrdv_reg;
    assign req_valid  = !fifo_empty;
    assign req_flit   = reqflit_t'(fifo_dout);
    assign occupancy  = fifo_count;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_snf_rxreq.sv
// Directed bench for snf_rxreq with a queue-based reference model that is
// checked against the DUT on every falling clock edge.
module tb_snf_rxreq;
    import snf_rxreq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    reqflit_t         flit;
    logic             flitv;
    logic             pend;
    logic             lcrdv;
    logic             req_valid;
    logic             req_ready;
    reqflit_t         req_flit;
    logic [CNT_W-1:0] occupancy;
    logic             proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int       m_lcrd;
    bit       m_lcrdv;
    bit       m_err;
    reqflit_t mq[$];
    int       popped[$];
    bit       log_en = 1'b0;

    always #5 clock = ~clock;

    snf_rxreq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .RXREQFLIT     (flit),
        .RXREQFLITV    (flitv),
        .RXREQFLITPEND (pend),
        .RXREQLCRDV    (lcrdv),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_flit      (req_flit),
        .occupancy     (occupancy),
        .proto_err     (proto_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic reqflit_t mk(input logic [5:0] op, input logic [47:0] a, input int t);
        reqflit_t f;
        f        = '0;
        f.opcode = op;
        f.addr   = a;
        f.txn_id = 12'(t);
        f.src_id = 11'h021;
        f.tgt_id = 11'h005;
        f.size   = 3'd6;
        return f;
    endfunction

    task automatic model_reset();
        m_lcrd  = 0;
        m_lcrdv = 1'b0;
        m_err   = 1'b0;
        mq.delete();
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reset discards everything the instant it is asserted
    always @(negedge reset) model_reset();

    // Model step: credits granted last cycle are usable now; a flit needs a
    // credit; buffer space is released by a same-cycle pop
    always @(posedge clock) begin : model_step
        bit pop_now;
        if (!reset) begin
            model_reset();
        end else begin
            pop_now = (mq.size() > 0) && req_ready;
            m_lcrd  = m_lcrd + int'(m_lcrdv);
            if (flitv) begin
                if (m_lcrd == 0)
                    m_err = 1'b1;
                else if (flit.opcode == ReqLCrdReturn)
                    m_lcrd--;
                else if (mq.size() == DEPTH && !pop_now)
                    m_err = 1'b1;
                else begin
                    m_lcrd--;
                    mq.push_back(flit);
                end
            end
            if (pop_now) mq.delete(0);
            m_lcrdv = (m_lcrd + mq.size()) < DEPTH;
        end
    end

    // Per-cycle comparison against the model, plus a log of delivered TxnIDs
    always @(negedge clock) begin
        chk("lcrdv", lcrdv, m_lcrdv);
        chk("req_valid", req_valid, mq.size() != 0);
        chk("occupancy", occupancy, mq.size());
        chk("proto_err", proto_err, m_err);
        if (mq.size() != 0) chk("req_flit", req_flit, mq[0]);
        if (reset && log_en && req_valid && req_ready) popped.push_back(int'(req_flit.txn_id));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        flit      = '0;
        flitv     = 1'b0;
        pend      = 1'b0;
        req_ready = 1'b0;
        reset     = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_lcrdv", lcrdv, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_flit", req_flit, 0);
        chk("rst_err", proto_err, 0);

        // Release: exactly DEPTH grant cycles
        reset  = 1'b1;
        grants = 0;
        repeat (8) begin cyc(); grants += int'(lcrdv); end
        chk("grant_burst", grants, 4);
        chk("model_lcrd_init", m_lcrd, 4);

        // Four ReadNoSnp, no pops
        log_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            flit  = mk(ReadNoSnp, 48'h1000 + 48'(i * 'h40), i + 1);
            flitv = 1'b1;
            pend  = 1'b1;
            cyc();
        end
        flitv = 1'b0;
        pend  = 1'b0;
        chk("occ_full", occupancy, 4);
        chk("head_txn1", req_flit.txn_id, 1);
        chk("head_addr", req_flit.addr, 48'h1000);
        chk("model_lcrd_empty", m_lcrd, 0);
        grants = 0;
        repeat (3) begin cyc(); grants += int'(lcrdv); end
        chk("no_grant_full", grants, 0);

        // Single pop: next head visible, one grant one cycle later
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        chk("head_txn2", req_flit.txn_id, 2);
        chk("regrant_pulse", lcrdv, 1);
        cyc();
        chk("regrant_single", lcrdv, 0);

        // Down to occupancy 2, then push+pop together across pointer wrap
        req_ready = 1'b1;
        cyc();
        chk("occ_two", occupancy, 2);
        for (int t = 5; t <= 9; t++) begin
            flit  = mk(ReadNoSnp, 48'h1000 + 48'((t - 1) * 'h40), t);
            flitv = 1'b1;
            cyc();
            chk("stream_occ", occupancy, 2);
        end
        flitv = 1'b0;
        cyc();
        cyc();
        req_ready = 1'b0;
        log_en    = 1'b0;
        chk("drain_occ", occupancy, 0);
        chk("pop_count", popped.size(), 9);
        for (int i = 0; i < popped.size() && i < 9; i++) chk("pop_order", popped[i], i + 1);

        // Credit return with three credits outstanding
        repeat (6) cyc();
        chk("model_lcrd_refill", m_lcrd, 4);
        flit  = mk(WriteNoSnpFull, 48'h2000, 10);
        flitv = 1'b1;
        cyc();
        flitv = 1'b0;
        chk("model_lcrd_three", m_lcrd, 3);
        chk("occ_one", occupancy, 1);
        chk("no_grant_occ1", lcrdv, 0);
        flit  = mk(ReqLCrdReturn, 48'h0, 0);
        flitv = 1'b1;
        cyc();
        flitv = 1'b0;
        chk("model_lcrd_ret", m_lcrd, 2);
        chk("ret_valid", req_valid, 1);
        chk("ret_occ", occupancy, 1);
        chk("ret_regrant", lcrdv, 1);
        grants = 0;
        repeat (4) begin cyc(); grants += int'(lcrdv); end
        chk("ret_single_regrant", grants, 0);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        repeat (4) cyc();
        chk("model_lcrd_back", m_lcrd, 4);

        // Spend all credits, then send one more flit
        for (int i = 0; i < 4; i++) begin
            flit  = mk(WriteNoSnpPtl, 48'h3000 + 48'(i * 'h40), 11 + i);
            flitv = 1'b1;
            cyc();
        end
        flitv = 1'b0;
        chk("pre_err", proto_err, 0);
        flit  = mk(ReadNoSnp, 48'h4000, 15);
        flitv = 1'b1;
        cyc();
        flitv = 1'b0;
        chk("err_set", proto_err, 1);
        chk("err_occ", occupancy, 4);
        chk("err_head", req_flit.txn_id, 11);
        req_ready = 1'b1;
        repeat (4) cyc();
        req_ready = 1'b0;
        repeat (6) cyc();
        chk("err_sticky", proto_err, 1);
        chk("err_drained", occupancy, 0);

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            flit  = mk(ReadNoSnp, 48'h5000 + 48'(i * 'h40), 20 + i);
            flitv = 1'b1;
            cyc();
        end
        flitv = 1'b0;
        chk("mid_occ3", occupancy, 3);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_lcrdv", lcrdv, 0);
        chk("mid_rst_valid", req_valid, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_flit", req_flit, 0);
        chk("mid_rst_err", proto_err, 0);
        cyc();
        cyc();
        reset  = 1'b1;
        grants = 0;
        repeat (8) begin cyc(); grants += int'(lcrdv); end
        chk("regrant_burst", grants, 4);
        chk("post_rst_err", proto_err, 0);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
